// File: rtl/hisoc_pkg.sv
// Shared definitions for the hisoc core slice.
//   XLEN          - architectural word width
//   NOP           - canonical no-op (addi x0, x0, 0), presented as a bubble word
//   fetch_state_e - fetch engine states
//   word_align    - clears the byte-offset bits of an address
package hisoc_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & {{(XLEN - 2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO used as the fetch instruction buffer.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   flush          - drops all entries; wins over a same-cycle write or read
//   wr_en, wr_data - push (ignored when full)
//   rd_en          - pop the head entry (ignored when empty)
//   rd_data        - head entry (meaningless when empty)
//   count, empty   - occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module inst_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CntW-1:0]  count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             full;
  logic             do_wr, do_rd;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign do_wr = wr_en && !full && !flush;
  assign do_rd = rd_en && !empty && !flush;

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues word reads to a 1-cycle-latency ROM, buffers
// {instruction, pc} pairs in inst_fifo and hands them to decode with a
// valid/ready handshake. A redirect flushes the buffer and restarts fetch.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   enable                      - fetch permitted when high
//   rom_en, rom_addr, rom_rdata - ROM read strobe / byte address / data (next cycle)
//   if_valid, if_ready          - decode handshake
//   if_inst, if_pc              - head instruction and its pc
//   redirect_valid, redirect_pc - branch/jump redirect
module inst_fetch
  import hisoc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  output logic            rom_en,
  output logic [XLEN-1:0] rom_addr,
  input  logic [XLEN-1:0] rom_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EntryW = 2 * XLEN;
  localparam logic [XLEN-1:0] ResetPcAligned = word_align(RESET_PC);

  fetch_state_e    state_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q;
  logic            inflight_q;

  logic [CntW-1:0]   fifo_count;
  logic              fifo_empty;
  logic [EntryW-1:0] fifo_head;
  logic              fifo_wr, fifo_pop;
  logic              credit;
  logic              resp_kill;

  // A read is only issued if its data is guaranteed a slot. The in-flight read
  // already owns one, and a pop this cycle is not counted so the check stays
  // purely registered.
  assign credit = ({1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q}) < (CntW + 1)'(FIFO_DEPTH);

  assign rom_en   = !rst && (state_q == StRun) && enable && !redirect_valid && credit;
  assign rom_addr = rst ? ResetPcAligned : fetch_pc_q;

  // The response arriving during a redirect belongs to the old path.
  assign resp_kill = redirect_valid;
  assign fifo_wr   = inflight_q && !resp_kill;

  assign if_valid = !rst && !fifo_empty;
  assign fifo_pop = if_valid && if_ready;
  assign if_inst  = rst ? '0 : (if_valid ? fifo_head[EntryW-1:XLEN] : NOP);
  assign if_pc    = if_valid ? fifo_head[XLEN-1:0] : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
    end else if (rom_en) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      fetch_pc_q    <= ResetPcAligned;
      inflight_q    <= 1'b0;
      inflight_pc_q <= ResetPcAligned;
    end else begin
      unique case (state_q)
        StIdle: if (enable) state_q <= StRun;
        StRun:  if (!enable) state_q <= StIdle;
      endcase
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= rom_en;
      if (rom_en) begin
        inflight_pc_q <= fetch_pc_q;
      end
    end
  end

  inst_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EntryW)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (redirect_valid),
    .wr_en  (fifo_wr),
    .wr_data({rom_rdata, inflight_pc_q}),
    .rd_en  (fifo_pop),
    .rd_data(fifo_head),
    .count  (fifo_count),
    .empty  (fifo_empty)
  );

endmodule
